// File: rtl/mc_pad_pkg.sv
// Shared types and register indices for the GPIO pad bank.
package mc_pad_pkg;

    // Pad cell flavour selected per pad at elaboration time.
    typedef enum logic [1:0] {
        PAD_PLAIN  = 2'd0,
        PAD_PULLUP = 2'd1,
        PAD_PULLDN = 2'd2
    } pad_type_e;

    // Word register indices on the configuration bus.
    localparam logic [2:0] RegDir      = 3'd0;
    localparam logic [2:0] RegOut      = 3'd1;
    localparam logic [2:0] RegIn       = 3'd2;
    localparam logic [2:0] RegDebounce = 3'd3;
    localparam logic [2:0] RegRise     = 3'd4;
    localparam logic [2:0] RegFall     = 3'd5;
    localparam logic [2:0] RegIrqEn    = 3'd6;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } cfg_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } cfg_rsp_t;

endpackage

// File: rtl/mc_pad_debounce.sv
// Per-pad input conditioning: synchroniser chain, saturating mismatch
// counter, debounced level and single-cycle edge events.
module mc_pad_debounce #(
    parameter int SyncStages = 2,
    parameter int DebounceW  = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 pad_in,
    input  logic [DebounceW-1:0] thresh,
    output logic                 deb,
    output logic                 rise,
    output logic                 fall
);

    logic [SyncStages-1:0] sync_reg;
    logic [DebounceW-1:0]  cnt_reg;
    logic [DebounceW-1:0]  cnt_next;
    logic                  deb_reg;
    logic                  deb_next;
    logic                  sync;

    assign sync = sync_reg[SyncStages-1];

    // Shift the raw pad value through the synchroniser flops.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], pad_in};
        end
    end

    // Count mismatching cycles; accept the new level once the count has
    // reached the threshold (>= so a lowered threshold applies at once).
    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (sync == deb_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= thresh) begin
            deb_next = sync;
            cnt_next = '0;
        end else if (cnt_reg != {DebounceW{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            deb_reg <= deb_next;
        end
    end

    // Edge events coincide with the clock edge that updates deb.
    assign deb  = deb_reg;
    assign rise = deb_next & ~deb_reg;
    assign fall = ~deb_next & deb_reg;

endmodule

// File: rtl/mc_pad_io_cells.sv
// Behavioural stand-ins for the IHP13 bidirectional GPIO pad cells.
// din drives the pin while oen is low; dout always reflects the pin.

module mc_pad_io (
    inout  wire  pad,
    input  logic din,
    input  logic oen,
    output logic dout
);
    assign pad  = oen ? 1'bz : din;
    assign dout = pad;
endmodule

module mc_pad_io_pu (
    inout  wire  pad,
    input  logic din,
    input  logic oen,
    output logic dout
);
    pullup (pad);
    assign pad  = oen ? 1'bz : din;
    assign dout = pad;
endmodule

module mc_pad_io_pd (
    inout  wire  pad,
    input  logic din,
    input  logic oen,
    output logic dout
);
    pulldown (pad);
    assign pad  = oen ? 1'bz : din;
    assign dout = pad;
endmodule

// File: rtl/mc_pad_gpio_bank.sv
// Bank of bidirectional GPIO pads with register-bus control, debounced
// inputs, sticky edge capture and a level interrupt.
module mc_pad_gpio_bank
    import mc_pad_pkg::*;
#(
    parameter int                       NumPads    = 8,
    parameter pad_type_e [NumPads-1:0]  PadType    = {NumPads{PAD_PLAIN}},
    parameter int                       SyncStages = 2,
    parameter int                       DebounceW  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    inout  wire  [NumPads-1:0] pad_io,
    input  logic        cfg_req_i,
    input  logic        cfg_we_i,
    input  logic [2:0]  cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_gnt_o,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        irq_o
);

    cfg_req_t cfg_req;
    cfg_rsp_t cfg_rsp;

    logic [NumPads-1:0]   dir_reg;
    logic [NumPads-1:0]   dir_d1_reg;
    logic [NumPads-1:0]   out_reg;
    logic [NumPads-1:0]   rise_reg;
    logic [NumPads-1:0]   fall_reg;
    logic [NumPads-1:0]   irq_en_reg;
    logic [DebounceW-1:0] thresh_reg;
    logic                 rvalid_reg;
    logic [31:0]          rdata_reg;
    logic                 irq_reg;

    logic [NumPads-1:0]   oe;
    logic [NumPads-1:0]   pad_in;
    logic [NumPads-1:0]   deb;
    logic [NumPads-1:0]   rise_evt;
    logic [NumPads-1:0]   fall_evt;
    logic [31:0]          rd_word;
    logic                 wr_en;
    logic [NumPads-1:0]   wr_pads;
    logic                 unused_wdata;

    assign cfg_req.req   = cfg_req_i;
    assign cfg_req.we    = cfg_we_i;
    assign cfg_req.addr  = cfg_addr_i;
    assign cfg_req.wdata = cfg_wdata_i;

    assign wr_en        = cfg_req.req & cfg_req.we;
    assign wr_pads      = cfg_req.wdata[NumPads-1:0];
    assign unused_wdata = ^cfg_req.wdata;

    // Drive only once dir has been set for a full cycle so the pin data has
    // settled; dropping dir releases the pin in the same cycle.
    assign oe = dir_reg & dir_d1_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NumPads; gi++) begin : gen_pad
            if (PadType[gi] == PAD_PULLUP) begin : gen_pu
                mc_pad_io_pu u_cell (
                    .pad  (pad_io[gi]),
                    .din  (out_reg[gi]),
                    .oen  (~oe[gi]),
                    .dout (pad_in[gi])
                );
            end else if (PadType[gi] == PAD_PULLDN) begin : gen_pd
                mc_pad_io_pd u_cell (
                    .pad  (pad_io[gi]),
                    .din  (out_reg[gi]),
                    .oen  (~oe[gi]),
                    .dout (pad_in[gi])
                );
            end else begin : gen_plain
                mc_pad_io u_cell (
                    .pad  (pad_io[gi]),
                    .din  (out_reg[gi]),
                    .oen  (~oe[gi]),
                    .dout (pad_in[gi])
                );
            end

            mc_pad_debounce #(
                .SyncStages (SyncStages),
                .DebounceW  (DebounceW)
            ) u_deb (
                .clk    (clk_i),
                .srst   (rst_i),
                .pad_in (pad_in[gi]),
                .thresh (thresh_reg),
                .deb    (deb[gi]),
                .rise   (rise_evt[gi]),
                .fall   (fall_evt[gi])
            );
        end
    endgenerate

    // Read multiplexer over the current register contents, zero-extended.
    always_comb begin
        rd_word = '0;
        case (cfg_req.addr)
            RegDir:      rd_word[NumPads-1:0]   = dir_reg;
            RegOut:      rd_word[NumPads-1:0]   = out_reg;
            RegIn:       rd_word[NumPads-1:0]   = deb;
            RegDebounce: rd_word[DebounceW-1:0] = thresh_reg;
            RegRise:     rd_word[NumPads-1:0]   = rise_reg;
            RegFall:     rd_word[NumPads-1:0]   = fall_reg;
            RegIrqEn:    rd_word[NumPads-1:0]   = irq_en_reg;
            default:     rd_word                = '0;
        endcase
    end

    // Control registers, sticky edge bits (new edge beats a W1C) and irq.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_reg    <= '0;
            dir_d1_reg <= '0;
            out_reg    <= '0;
            rise_reg   <= '0;
            fall_reg   <= '0;
            irq_en_reg <= '0;
            thresh_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            dir_d1_reg <= dir_reg;
            if (wr_en && cfg_req.addr == RegDir)      dir_reg    <= wr_pads;
            if (wr_en && cfg_req.addr == RegOut)      out_reg    <= wr_pads;
            if (wr_en && cfg_req.addr == RegIrqEn)    irq_en_reg <= wr_pads;
            if (wr_en && cfg_req.addr == RegDebounce) thresh_reg <= cfg_req.wdata[DebounceW-1:0];
            rise_reg <= (rise_reg & ~((wr_en && cfg_req.addr == RegRise) ? wr_pads : '0)) | rise_evt;
            fall_reg <= (fall_reg & ~((wr_en && cfg_req.addr == RegFall) ? wr_pads : '0)) | fall_evt;
            irq_reg  <= |((rise_reg | fall_reg) & irq_en_reg);
        end
    end

    // Registered bus response: one rvalid per granted request, data only for reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= cfg_req.req;
            rdata_reg  <= (cfg_req.req && !cfg_req.we) ? rd_word : 32'h0;
        end
    end

    assign cfg_rsp.gnt    = cfg_req.req;
    assign cfg_rsp.rvalid = rvalid_reg;
    assign cfg_rsp.rdata  = rdata_reg;

    assign cfg_gnt_o    = cfg_rsp.gnt;
    assign cfg_rvalid_o = cfg_rsp.rvalid;
    assign cfg_rdata_o  = cfg_rsp.rdata;
    assign irq_o        = irq_reg;

endmodule

// File: tb/tb_mc_pad_gpio_bank.sv
// Directed bench for mc_pad_gpio_bank: bus responses are checked by a
// scoreboard monitor, pad/OE/irq timing is checked inline.
module tb_mc_pad_gpio_bank;
    import mc_pad_pkg::*;

    localparam int NP = 8;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic        irq;
    wire  [NP-1:0] pad_io;
    logic [NP-1:0] drv_en;
    logic [NP-1:0] drv_val;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : gen_drv
            assign pad_io[gi] = drv_en[gi] ? drv_val[gi] : 1'bz;
        end
    endgenerate

    mc_pad_gpio_bank #(
        .NumPads    (NP),
        .SyncStages (2),
        .DebounceW  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pad_io       (pad_io),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_gnt_o    (cfg_gnt),
        .cfg_rvalid_o (cfg_rvalid),
        .cfg_rdata_o  (cfg_rdata),
        .irq_o        (irq)
    );

    // Scoreboard monitor: every rvalid pops one expectation.
    always @(negedge clk) begin
        if (cfg_rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: rdata=0x%08h required no response", cfg_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cfg_rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL %s: rdata=0x%08h required 0x%08h", e.name, cfg_rdata, e.data);
                end else begin
                    $display("rsp %s: rdata=0x%08h", e.name, cfg_rdata);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input string nm);
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        exp_q.push_back('{nm, 32'h0});
        step();
        if (cfg_gnt !== 1'b0) begin end
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] expv, input string nm);
        cfg_req   = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = a;
        cfg_wdata = 32'h0;
        exp_q.push_back('{nm, expv});
        step();
        cfg_req = 1'b0;
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst       = 1'b1;
        cfg_req   = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_wdata = 32'h0;
        drv_en    = '1;
        drv_val   = '0;

        // Reset: two cycles, then everything reads zero.
        step();
        step();
        rst = 1'b0;
        check("reset_oe", 32'(dut.oe), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("gnt_comb", 32'(cfg_gnt), 32'h0);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), 32'h0, $sformatf("reset_read_%0d", a));
        end

        // OE sequencing: data first, OE one cycle after dir.
        bus_write(RegOut, 32'h05, "wr_out");
        drv_en = 8'hFA;
        bus_write(RegDir, 32'h05, "wr_dir");
        check("oe_after_dir_set", 32'(dut.oe), 32'h0);
        step();
        check("oe_one_cycle_later", 32'(dut.oe), 32'h05);
        check("pads_driven", 32'(pad_io & 8'h05), 32'h05);
        // Back-to-back reads.
        bus_read(RegDir, 32'h05, "b2b_read_dir");
        bus_read(3'd7, 32'h0, "b2b_read_7");
        bus_write(RegDir, 32'h0, "wr_dir_clear");
        check("oe_drop_same_cycle", 32'(dut.oe), 32'h0);
        drv_en = '1;
        repeat (10) step();
        bus_write(RegRise, 32'hFF, "clr_rise");
        bus_write(RegFall, 32'hFF, "clr_fall");
        bus_read(RegRise, 32'h0, "rise_cleared");
        bus_read(RegFall, 32'h0, "fall_cleared");

        // Debounce threshold 3, short pulse is filtered.
        bus_write(RegDebounce, 32'h103, "wr_debounce3");
        bus_read(RegDebounce, 32'h03, "rd_debounce3");
        bus_write(RegIrqEn, 32'h02, "wr_irq_en");
        bus_read(RegIrqEn, 32'h02, "rd_irq_en");
        drv_val[1] = 1'b1;
        repeat (3) step();
        drv_val[1] = 1'b0;
        repeat (12) step();
        check("pulse_filtered_deb", 32'(dut.deb), 32'h0);
        bus_read(RegIn, 32'h0, "pulse_filtered_in");
        bus_read(RegRise, 32'h0, "pulse_no_rise");

        // Stable high: IN[1] after exactly 2+3+1 cycles, irq one later.
        drv_val[1] = 1'b1;
        repeat (5) step();
        check("deb_before_6", 32'(dut.deb[1]), 32'h0);
        step();
        check("deb_at_6", 32'(dut.deb[1]), 32'h1);
        check("irq_not_yet", 32'(irq), 32'h0);
        step();
        check("irq_after_rise", 32'(irq), 32'h1);
        bus_read(RegIn, 32'h02, "in_high");
        bus_read(RegRise, 32'h02, "rise_set");

        // Debounce 0: three-cycle latency.
        bus_write(RegDebounce, 32'h0, "wr_debounce0");
        drv_val[1] = 1'b0;
        repeat (2) step();
        check("deb0_before_3", 32'(dut.deb[1]), 32'h1);
        step();
        check("deb0_at_3", 32'(dut.deb[1]), 32'h0);
        repeat (2) step();
        bus_read(RegFall, 32'h02, "fall_set");
        check("irq_held", 32'(irq), 32'h1);

        // W1C both sticky bits; irq falls the cycle after the last clear.
        bus_write(RegRise, 32'h02, "w1c_rise");
        check("irq_fall_pending", 32'(irq), 32'h1);
        bus_write(RegFall, 32'h02, "w1c_fall");
        check("irq_still_1", 32'(irq), 32'h1);
        step();
        check("irq_cleared", 32'(irq), 32'h0);
        bus_read(RegRise, 32'h0, "rise_after_w1c");
        bus_read(RegFall, 32'h0, "fall_after_w1c");

        // W1C landing on the same edge as a new rise: set wins.
        drv_val[1] = 1'b1;
        repeat (2) step();
        bus_write(RegRise, 32'h02, "w1c_collide");
        bus_read(RegRise, 32'h02, "rise_set_wins");
        bus_write(RegRise, 32'h02, "w1c_again");
        bus_read(RegRise, 32'h0, "rise_cleared_again");

        // Writes to IN and to index 7 are ignored.
        bus_write(RegIn, 32'h0, "wr_in_ignored");
        bus_read(RegIn, 32'h02, "in_unchanged");
        bus_write(3'd7, 32'hFFFF_FFFF, "wr_7_ignored");
        bus_read(3'd7, 32'h0, "rd_7_zero");
        bus_write(RegOut, 32'hFFFF_FF00, "wr_out_high_bits");
        bus_read(RegOut, 32'h0, "out_upper_bits_zero");

        // Reset mid-debounce while all pads are driven.
        bus_write(RegDebounce, 32'h05, "wr_debounce5");
        bus_write(RegDir, 32'hFF, "wr_dir_all");
        drv_en = '0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step();
            if (dut.gen_pad[1].u_deb.cnt_reg == 8'd2) found = 1'b1;
        end
        check("cnt_reached_2", 32'(found), 32'h1);
        check("oe_all_before_rst", 32'(dut.oe), 32'hFF);
        rst = 1'b1;
        step();
        check("rst_mid_oe", 32'(dut.oe), 32'h0);
        check("rst_mid_cnt", 32'(dut.gen_pad[1].u_deb.cnt_reg), 32'h0);
        drv_en  = '1;
        drv_val = '0;
        step();
        rst = 1'b0;
        repeat (10) step();
        bus_read(RegRise, 32'h0, "post_rst_rise");
        bus_read(RegFall, 32'h0, "post_rst_fall");
        bus_read(RegIn, 32'h0, "post_rst_in");
        bus_read(RegDir, 32'h0, "post_rst_dir");
        check("post_rst_irq", 32'(irq), 32'h0);

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
